// File: rtl/gb_cpu_common_pkg.sv
// Shared Game Boy CPU types: register-file byte selectors, bus T-state
// encoding and the memory-map constants used by the bus controller.
package gb_cpu_common_pkg;

  typedef enum logic [3:0] {
    REG_B     = 4'h0,
    REG_C     = 4'h1,
    REG_D     = 4'h2,
    REG_E     = 4'h3,
    REG_H     = 4'h4,
    REG_L     = 4'h5,
    REG_A     = 4'h6,
    REG_F     = 4'h7,
    REG_IR    = 4'h8,
    REG_TMP_L = 4'h9,
    REG_TMP_H = 4'hA
  } regfile_r8_t;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    T4
  } bus_tstate_t;

  localparam logic [15:0] HRAM_START    = 16'hFF80;
  localparam logic [15:0] HRAM_END      = 16'hFFFE;
  localparam logic [7:0]  OPEN_BUS_DATA = 8'hFF;

  // Only these three destinations are reachable from the data-bus write port.
  function automatic logic is_data_bus_dest(input regfile_r8_t dest);
    return (dest == REG_IR) || (dest == REG_TMP_L) || (dest == REG_TMP_H);
  endfunction

  function automatic logic in_hram(input logic [15:0] addr);
    return (addr >= HRAM_START) && (addr <= HRAM_END);
  endfunction

endpackage

// File: rtl/gb_cpu_bus_ctrl_if.sv
// Request, system-bus and regfile data-bus signals of the CPU bus controller.
// The slave modport is the controller's view; master is the surrounding system.
interface gb_cpu_bus_ctrl_if
  import gb_cpu_common_pkg::*;
();

  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  regfile_r8_t req_dest;
  logic        req_ready;
  logic        busy;

  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        oam_dma_active;

  regfile_r8_t data_bus_req;
  logic [7:0]  data_bus_data;
  logic        data_bus_wren;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_dest,
    output req_ready, busy,
    output bus_addr, bus_wdata, bus_rd, bus_wr,
    input  bus_rdata, oam_dma_active,
    output data_bus_req, data_bus_data, data_bus_wren
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_dest,
    input  req_ready, busy,
    input  bus_addr, bus_wdata, bus_rd, bus_wr,
    output bus_rdata, oam_dma_active,
    input  data_bus_req, data_bus_data, data_bus_wren
  );

endinterface

// File: rtl/gb_cpu_bus_ctrl.sv
// Game Boy CPU bus controller: runs each M-cycle as T1..T4 on the system bus
// and returns read bytes to the regfile. Define GB_CPU_BUS_DMA_BLOCK_EN to
// block non-HRAM accesses while OAM DMA is active.
module gb_cpu_bus_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  gb_cpu_bus_ctrl_if.slave   bus
);

  bus_tstate_t state;
  logic        lat_write;
  logic        lat_blocked;
  regfile_r8_t lat_dest;
  logic        req_ready_q;
  logic        rd_q;
  logic        wr_q;
  logic        wren_q;
  logic        accept;
  logic        req_blocked;

  assign accept = bus.req_valid && req_ready_q;

`ifdef GB_CPU_BUS_DMA_BLOCK_EN
  assign req_blocked = bus.oam_dma_active && !in_hram(bus.req_addr);
`else
  logic unused_dma;
  assign unused_dma  = bus.oam_dma_active;
  assign req_blocked = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      lat_write         <= 1'b0;
      lat_blocked       <= 1'b0;
      lat_dest          <= REG_IR;
      req_ready_q       <= 1'b1;
      bus.busy          <= 1'b0;
      bus.bus_addr      <= 16'h0000;
      bus.bus_wdata     <= 8'h00;
      rd_q              <= 1'b0;
      wr_q              <= 1'b0;
      bus.data_bus_req  <= REG_IR;
      bus.data_bus_data <= 8'h00;
      wren_q            <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      case (state)
        IDLE, T4: begin
          if (accept) begin
            state         <= T1;
            lat_write     <= bus.req_write;
            lat_blocked   <= req_blocked;
            lat_dest      <= bus.req_dest;
            req_ready_q   <= 1'b0;
            bus.busy      <= 1'b1;
            bus.bus_addr  <= bus.req_addr;
            bus.bus_wdata <= bus.req_write ? bus.req_wdata : 8'h00;
            rd_q          <= !bus.req_write && !req_blocked;
            wr_q          <= 1'b0;
          end else begin
            state         <= IDLE;
            req_ready_q   <= 1'b1;
            bus.busy      <= 1'b0;
            bus.bus_addr  <= 16'h0000;
            bus.bus_wdata <= 8'h00;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
          end
        end
        T1: begin
          state <= T2;
          wr_q  <= lat_write && !lat_blocked;
        end
        T2: state <= T3;
        T3: begin
          // End of T3 is the read sample point; a blocked read floats high.
          state             <= T4;
          req_ready_q       <= 1'b1;
          rd_q              <= 1'b0;
          wr_q              <= 1'b0;
          bus.data_bus_req  <= lat_dest;
          bus.data_bus_data <= lat_blocked ? OPEN_BUS_DATA : bus.bus_rdata;
          wren_q            <= !lat_write && is_data_bus_dest(lat_dest);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are cut the moment reset rises so an aborted cycle never
  // reaches memory or the regfile.
  assign bus.bus_rd        = rd_q && !reset;
  assign bus.bus_wr        = wr_q && !reset;
  assign bus.data_bus_wren = wren_q && !reset;
  assign bus.req_ready     = req_ready_q;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Directed bench for gb_cpu_bus_ctrl: single reads/writes, back-to-back reads,
// mid-cycle reset, illegal destination and (if enabled) OAM DMA blocking.
module tb_gb_cpu_bus_ctrl;
  import gb_cpu_common_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  gb_cpu_bus_ctrl_if bif ();

  gb_cpu_bus_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance one clk; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(bif.req_ready), 32'd1);
    check({tag, "_busy"},  32'(bif.busy), 32'd0);
    check({tag, "_addr"},  32'(bif.bus_addr), 32'h0000);
    check({tag, "_rd"},    32'(bif.bus_rd), 32'd0);
    check({tag, "_wr"},    32'(bif.bus_wr), 32'd0);
    check({tag, "_wren"},  32'(bif.data_bus_wren), 32'd0);
  endtask

  // One isolated M-cycle issued from IDLE, checked in every T-state.
  task automatic mcycle(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wdata, input regfile_r8_t dest,
                        input logic [7:0] rdata, input logic strobe_en,
                        input logic exp_wren, input logic [7:0] exp_data);
    bif.req_valid = 1'b1;
    bif.req_write = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_dest  = dest;
    bif.bus_rdata = ~rdata;
    step();
    bif.req_valid = 1'b0;
    bif.req_addr  = 16'hDEAD;
    bif.req_wdata = 8'h5A;
    for (int t = 1; t <= 4; t++) begin
      string ts;
      ts = $sformatf("%s_t%0d", tag, t);
      check({ts, "_busy"},  32'(bif.busy), 32'd1);
      check({ts, "_ready"}, 32'(bif.req_ready), 32'(t == 4));
      check({ts, "_addr"},  32'(bif.bus_addr), 32'(addr));
      check({ts, "_rd"},    32'(bif.bus_rd), 32'(!wr && strobe_en && t <= 3));
      check({ts, "_wr"},    32'(bif.bus_wr), 32'(wr && strobe_en && (t == 2 || t == 3)));
      check({ts, "_wren"},  32'(bif.data_bus_wren), 32'(exp_wren && t == 4));
      if (wr) check({ts, "_wdata"}, 32'(bif.bus_wdata), 32'(wdata));
      if (t == 4 && exp_wren) begin
        check({ts, "_dreq"},  32'(bif.data_bus_req), 32'(dest));
        check({ts, "_ddata"}, 32'(bif.data_bus_data), 32'(exp_data));
      end
      if (t == 3) bif.bus_rdata = rdata;
      step();
      if (t == 3) bif.bus_rdata = ~rdata;
    end
    check_idle({tag, "_end"});
  endtask

  typedef struct {
    logic [15:0] addr;
    regfile_r8_t dest;
    logic [7:0]  rdata;
  } b2b_t;

  b2b_t b2b [3];
  int   wren_at [$];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bif.req_valid      = 1'b0;
    bif.req_write      = 1'b0;
    bif.req_addr       = 16'h0000;
    bif.req_wdata      = 8'h00;
    bif.req_dest       = REG_IR;
    bif.bus_rdata      = 8'h00;
    bif.oam_dma_active = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_idle("rst");
    check("rst_wdata", 32'(bif.bus_wdata), 32'h00);
    check("rst_dreq",  32'(bif.data_bus_req), 32'(REG_IR));
    check("rst_ddata", 32'(bif.data_bus_data), 32'h00);

    mcycle("rd_ir", 1'b0, 16'h0150, 8'h00, REG_IR, 8'h3E, 1'b1, 1'b1, 8'h3E);
    mcycle("wr_c000", 1'b1, 16'hC000, 8'hA5, REG_IR, 8'h00, 1'b1, 1'b0, 8'h00);

    // Three back-to-back reads with req_valid held; next request presented in T4.
    b2b[0] = '{16'h2000, REG_TMP_L, 8'h11};
    b2b[1] = '{16'h2001, REG_TMP_H, 8'h22};
    b2b[2] = '{16'h2002, REG_IR,    8'h33};
    bif.req_valid = 1'b1;
    bif.req_write = 1'b0;
    bif.req_addr  = b2b[0].addr;
    bif.req_dest  = b2b[0].dest;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      int k;
      int t;
      step();
      k = (cyc - 1) / 4;
      t = (cyc - 1) % 4 + 1;
      check($sformatf("b2b_c%0d_ready", cyc), 32'(bif.req_ready), 32'(t == 4));
      check($sformatf("b2b_c%0d_addr", cyc), 32'(bif.bus_addr), 32'(b2b[k].addr));
      if (bif.data_bus_wren) wren_at.push_back(cyc);
      if (t == 3) bif.bus_rdata = b2b[k].rdata;
      if (t == 4) begin
        check($sformatf("b2b_c%0d_dreq", cyc), 32'(bif.data_bus_req), 32'(b2b[k].dest));
        check($sformatf("b2b_c%0d_ddata", cyc), 32'(bif.data_bus_data), 32'(b2b[k].rdata));
        if (k < 2) begin
          bif.req_addr = b2b[k + 1].addr;
          bif.req_dest = b2b[k + 1].dest;
        end else begin
          bif.req_valid = 1'b0;
        end
      end
    end
    check("b2b_npulses", 32'(wren_at.size()), 32'd3);
    if (wren_at.size() == 3) begin
      check("b2b_first", 32'(wren_at[0]), 32'd4);
      check("b2b_gap1", 32'(wren_at[1] - wren_at[0]), 32'd4);
      check("b2b_gap2", 32'(wren_at[2] - wren_at[1]), 32'd4);
    end
    step();
    check_idle("b2b_end");

    // Reset raised at the start of T2 of a write.
    bif.req_valid = 1'b1;
    bif.req_write = 1'b1;
    bif.req_addr  = 16'hC123;
    bif.req_wdata = 8'h3C;
    step();
    bif.req_valid = 1'b0;
    check("rstmid_t1_wr", 32'(bif.bus_wr), 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("rstmid_t2_wr", 32'(bif.bus_wr), 32'd0);
    check("rstmid_t2_wren", 32'(bif.data_bus_wren), 32'd0);
    step();
    check_idle("rstmid");
    check("rstmid_wdata", 32'(bif.bus_wdata), 32'h00);
    check("rstmid_dreq",  32'(bif.data_bus_req), 32'(REG_IR));
    check("rstmid_ddata", 32'(bif.data_bus_data), 32'h00);
    reset = 1'b0;
    step();
    check_idle("rstmid_rel");

    mcycle("rd_b", 1'b0, 16'h4000, 8'h00, REG_B, 8'h77, 1'b1, 1'b0, 8'h00);

    bif.oam_dma_active = 1'b1;
`ifdef GB_CPU_BUS_DMA_BLOCK_EN
    mcycle("dma_rd_blk", 1'b0, 16'h8000, 8'h00, REG_TMP_L, 8'h12, 1'b0, 1'b1, 8'hFF);
    mcycle("dma_rd_hram", 1'b0, 16'hFF90, 8'h00, REG_TMP_H, 8'h34, 1'b1, 1'b1, 8'h34);
    mcycle("dma_wr_blk", 1'b1, 16'hC000, 8'h99, REG_IR, 8'h00, 1'b0, 1'b0, 8'h00);
    mcycle("dma_rd_ffff", 1'b0, 16'hFFFF, 8'h00, REG_IR, 8'h56, 1'b0, 1'b1, 8'hFF);
`else
    mcycle("dma_ign_rd", 1'b0, 16'h8000, 8'h00, REG_TMP_L, 8'h12, 1'b1, 1'b1, 8'h12);
    mcycle("dma_ign_wr", 1'b1, 16'hC000, 8'h99, REG_IR, 8'h00, 1'b1, 1'b0, 8'h00);
`endif
    bif.oam_dma_active = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
